// File: rtl/divider_share_pkg.sv
// Shared types and defaults for the shared-divider front end.
package divider_share_pkg;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned BW_DATA_DEF = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/divider_share_rr_arb.sv
// Round-robin requester selection: first set bit of req at or after ptr, wrapping.
module divider_share_rr_arb
    import divider_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    always_comb begin
        int unsigned j;
        grant = '0;
        index = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/divider_share_ctrl.sv
// Shares one external divider among NUM_REQ requesters, one operation in flight.
// Define DIVIDER_SHARE_CTRL_CACHE_EN to add a one-entry result cache.
module divider_share_ctrl
    import divider_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned BW_DATA = BW_DATA_DEF
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_is_unsigned,
    input  logic [NUM_REQ*BW_DATA-1:0] req_numerator,
    input  logic [NUM_REQ*BW_DATA-1:0] req_denominator,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [BW_DATA-1:0]         rsp_quotient,
    output logic [BW_DATA-1:0]         rsp_remainder,
    output logic                       div_enable,
    output logic                       div_start,
    output logic                       div_is_unsigned,
    output logic [BW_DATA-1:0]         div_numerator,
    output logic [BW_DATA-1:0]         div_denominator,
    input  logic                       div_busy,
    input  logic [BW_DATA-1:0]         div_quotient,
    input  logic [BW_DATA-1:0]         div_remainder
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [BW_DATA-1:0]   quot_q, quot_d;
    logic [BW_DATA-1:0]   rem_q, rem_d;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     g_idx;
    logic                 g_any;
    logic [IDX_W-1:0]     rr_next;
    int unsigned          sel_base;
    logic                 sel_unsigned;
    logic [BW_DATA-1:0]   sel_num;
    logic [BW_DATA-1:0]   sel_den;
    logic                 accept;
    logic                 capture;
    logic                 cache_hit;
    logic [BW_DATA-1:0]   hit_quot;
    logic [BW_DATA-1:0]   hit_rem;

    divider_share_rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .grant(grant),
        .index(g_idx),
        .any  (g_any)
    );

    assign sel_base     = 32'(g_idx) * BW_DATA;
    assign sel_unsigned = req_is_unsigned[g_idx];
    assign sel_num      = req_numerator[sel_base +: BW_DATA];
    assign sel_den      = req_denominator[sel_base +: BW_DATA];
    assign rr_next      = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

    assign accept    = (state_q == IDLE) && g_any;
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign capture   = ((state_q == LAUNCH) || (state_q == WAIT)) && !div_busy;

    // Operands always follow the current grant; the divider only samples them on div_start.
    assign div_enable      = 1'b1;
    assign div_is_unsigned = sel_unsigned;
    assign div_numerator   = sel_num;
    assign div_denominator = sel_den;

    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;

`ifdef DIVIDER_SHARE_CTRL_CACHE_EN
    logic               cache_valid_q;
    logic               cache_uns_q;
    logic [BW_DATA-1:0] cache_num_q, cache_den_q, cache_quot_q, cache_rem_q;
    logic               op_uns_q;
    logic [BW_DATA-1:0] op_num_q, op_den_q;

    assign cache_hit = cache_valid_q && (cache_uns_q == sel_unsigned) &&
                       (cache_num_q == sel_num) && (cache_den_q == sel_den);
    assign hit_quot  = cache_quot_q;
    assign hit_rem   = cache_rem_q;

    // Operands are latched at accept since requesters may change them afterwards.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            cache_valid_q <= 1'b0;
            cache_uns_q   <= 1'b0;
            cache_num_q   <= '0;
            cache_den_q   <= '0;
            cache_quot_q  <= '0;
            cache_rem_q   <= '0;
            op_uns_q      <= 1'b0;
            op_num_q      <= '0;
            op_den_q      <= '0;
        end else begin
            if (accept) begin
                op_uns_q <= sel_unsigned;
                op_num_q <= sel_num;
                op_den_q <= sel_den;
            end
            if (capture) begin
                cache_valid_q <= 1'b1;
                cache_uns_q   <= op_uns_q;
                cache_num_q   <= op_num_q;
                cache_den_q   <= op_den_q;
                cache_quot_q  <= div_quotient;
                cache_rem_q   <= div_remainder;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_quot  = '0;
    assign hit_rem   = '0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        div_start = 1'b0;
        rsp_valid = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d  = g_idx;
                    rr_ptr_d = rr_next;
                    if (cache_hit) begin
                        quot_d  = hit_quot;
                        rem_d   = hit_rem;
                        state_d = RESP;
                    end else begin
                        div_start = 1'b1;
                        state_d   = LAUNCH;
                    end
                end
            end
            LAUNCH, WAIT: begin
                if (capture) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
        end
    end

endmodule

// File: tb/tb_divider_share_ctrl.sv
// Self-checking bench for divider_share_ctrl with a behavioural multi-cycle divider.
module tb_divider_share_ctrl;

    localparam int NR  = 4;
    localparam int BW  = 32;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rstnn;
    logic [NR-1:0]     req_valid, req_ready, req_is_unsigned, rsp_valid, rsp_ready;
    logic [NR*BW-1:0]  req_numerator, req_denominator;
    logic [BW-1:0]     rsp_quotient, rsp_remainder;
    logic              div_enable, div_start, div_is_unsigned, div_busy;
    logic [BW-1:0]     div_numerator, div_denominator, div_quotient, div_remainder;

    always #5 clk = ~clk;

    divider_share_ctrl #(
        .NUM_REQ(NR),
        .BW_DATA(BW)
    ) dut (
        .clk            (clk),
        .rstnn          (rstnn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_unsigned(req_is_unsigned),
        .req_numerator  (req_numerator),
        .req_denominator(req_denominator),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_quotient   (rsp_quotient),
        .rsp_remainder  (rsp_remainder),
        .div_enable     (div_enable),
        .div_start      (div_start),
        .div_is_unsigned(div_is_unsigned),
        .div_numerator  (div_numerator),
        .div_denominator(div_denominator),
        .div_busy       (div_busy),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder)
    );

    // Reference division: RISC-V style zero-divisor and overflow results, truncating.
    function automatic logic [63:0] div_ref(input logic uns, input logic [31:0] n,
                                            input logic [31:0] d);
        logic [31:0] q, r;
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = n;
        end else if (uns) begin
            q = n / d;
            r = n % d;
        end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = n;
            r = 32'd0;
        end else begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end
        return {q, r};
    endfunction

    function automatic bit is_fast(input logic uns, input logic [31:0] n, input logic [31:0] d);
        logic [31:0] an, ad;
        an = (!uns && n[31]) ? -n : n;
        ad = (!uns && d[31]) ? -d : d;
        if (d == 32'd0) return 1'b1;
        if (!uns && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return 1'b1;
        return an < ad;
    endfunction

    // Divider model: results valid only in the first non-busy cycle after start.
    logic [3:0]  dv_cnt;
    logic [63:0] dv_res;
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            dv_cnt <= '0;
            dv_res <= '0;
        end else if (div_start) begin
            dv_res <= div_ref(div_is_unsigned, div_numerator, div_denominator);
            dv_cnt <= is_fast(div_is_unsigned, div_numerator, div_denominator) ? 4'd1 : 4'(LAT + 1);
        end else if (dv_cnt != 4'd0) begin
            dv_cnt <= dv_cnt - 4'd1;
        end
    end
    assign div_busy      = dv_cnt > 4'd1;
    assign div_quotient  = (dv_cnt == 4'd1) ? dv_res[63:32] : 32'hDEAD_BEEF;
    assign div_remainder = (dv_cnt == 4'd1) ? dv_res[31:0]  : 32'hDEAD_BEEF;

    typedef struct {
        int          idx;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cycles = 0;
    int          rsp_count = 0;
    int          first_rsp_cycle = -1;
    bit          busy_seen = 1'b0;
    logic [NR-1:0] cur_rsp_valid, cur_req_ready;
    logic        cur_start, cur_busy;
    logic [BW-1:0] cur_q, cur_r;
    bit          acc_seen, hs_seen;
    int          acc_idx, acc_cycle;
    logic        acc_start;
    logic [NR-1:0] hs_valid;
    logic [BW-1:0] hs_q, hs_r;

    task automatic set_req(input int i, input logic uns, input logic [31:0] n,
                           input logic [31:0] d);
        req_is_unsigned[i]         = uns;
        req_numerator[i*BW +: BW]  = n;
        req_denominator[i*BW +: BW] = d;
        req_valid[i]               = 1'b1;
    endtask

    // One clock: sample at negedge, log accepts into the scoreboard, check responses.
    task automatic tick();
        logic [NR-1:0] acc;
        exp_t e;
        @(negedge clk);
        cycles++;
        cur_rsp_valid = rsp_valid;
        cur_req_ready = req_ready;
        cur_start     = div_start;
        cur_busy      = div_busy;
        cur_q         = rsp_quotient;
        cur_r         = rsp_remainder;
        if (div_busy) busy_seen = 1'b1;
        acc_seen = 1'b0;
        hs_seen  = 1'b0;
        acc      = req_valid & req_ready;
        if (div_start && dv_cnt != 4'd0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL start_while_busy: div_start=%b dv_cnt=%0d, required no start", div_start, dv_cnt);
        end
        if (acc != '0) begin
            acc_seen  = 1'b1;
            acc_start = div_start;
            acc_cycle = cycles;
            acc_idx   = 0;
            for (int i = NR - 1; i >= 0; i--) if (acc[i]) acc_idx = i;
            e.idx = acc_idx;
            {e.q, e.r} = div_ref(req_is_unsigned[acc_idx], req_numerator[acc_idx*BW +: BW],
                                 req_denominator[acc_idx*BW +: BW]);
            exp_q.push_back(e);
            grant_log.push_back(acc_idx);
        end
        if (rsp_valid != '0 && first_rsp_cycle < 0) first_rsp_cycle = cycles;
        if ((rsp_valid & rsp_ready) != '0) begin
            hs_seen  = 1'b1;
            hs_valid = rsp_valid;
            hs_q     = rsp_quotient;
            hs_r     = rsp_remainder;
            rsp_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp_valid !== NR'(1 << e.idx) || rsp_quotient !== e.q ||
                    rsp_remainder !== e.r) begin
                    tests_failed++;
                    $display("FAIL sb_rsp: got valid=%b q=%h r=%h, required valid=%b q=%h r=%h",
                             rsp_valid, rsp_quotient, rsp_remainder, NR'(1 << e.idx), e.q, e.r);
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (hs_seen) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL %s_timeout: no response within 100 cycles, required one", name);
    endtask

    task automatic apply_reset();
        rstnn     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstnn = 1'b1;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        @(negedge clk);
        tests_run += 6;
        if (req_ready !== '0)         begin tests_failed++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
        if (rsp_valid !== '0)         begin tests_failed++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        if (div_start !== 1'b0)       begin tests_failed++; $display("FAIL rst_div_start: got %b, required 0", div_start); end
        if (rsp_quotient !== '0)      begin tests_failed++; $display("FAIL rst_quot: got %h, required 0", rsp_quotient); end
        if (rsp_remainder !== '0)     begin tests_failed++; $display("FAIL rst_rem: got %h, required 0", rsp_remainder); end
        if (div_enable !== 1'b1)      begin tests_failed++; $display("FAIL rst_div_enable: got %b, required 1", div_enable); end
        apply_reset();
    endtask

    task automatic test_unsigned_basic();
        set_req(1, 1'b1, 32'd100, 32'd7);
        tick();
        tests_run++;
        if (!acc_seen || acc_idx != 1 || cur_req_ready !== 4'b0010 || acc_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL u_accept: seen=%0b idx=%0d ready=%b start=%b, required 1 1 0010 1",
                     acc_seen, acc_idx, cur_req_ready, acc_start);
        end
        wait_rsp("u");
        tests_run++;
        if (hs_valid !== 4'b0010 || hs_q !== 32'd14 || hs_r !== 32'd2) begin
            tests_failed++;
            $display("FAIL u_100_7: got valid=%b q=%0d r=%0d, required 0010 14 2", hs_valid, hs_q, hs_r);
        end
    endtask

    task automatic test_signed_zero();
        set_req(2, 1'b0, 32'hFFFF_FFF9, 32'd2);
        tick();
        wait_rsp("s");
        tests_run++;
        if (hs_q !== 32'hFFFF_FFFD || hs_r !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL s_m7_2: got q=%h r=%h, required fffffffd ffffffff", hs_q, hs_r);
        end
        set_req(0, 1'b1, 32'd5, 32'd0);
        first_rsp_cycle = -1;
        busy_seen = 1'b0;
        tick();
        wait_rsp("z");
        tests_run += 3;
        if (hs_q !== 32'hFFFF_FFFF || hs_r !== 32'd5) begin
            tests_failed++;
            $display("FAIL z_5_0: got q=%h r=%h, required ffffffff 5", hs_q, hs_r);
        end
        if (first_rsp_cycle - acc_cycle != 2) begin
            tests_failed++;
            $display("FAIL z_latency: got %0d cycles, required 2", first_rsp_cycle - acc_cycle);
        end
        if (busy_seen) begin
            tests_failed++;
            $display("FAIL z_busy: got busy during zero divide, required none");
        end
    endtask

    task automatic test_round_robin();
        int target;
        bit rereq;
        apply_reset();
        grant_log.delete();
        rereq = 1'b0;
        set_req(0, 1'b1, 32'd1000, 32'd3);
        set_req(1, 1'b1, 32'd2000, 32'd7);
        set_req(2, 1'b0, 32'hFFFF_F448, 32'd11);
        set_req(3, 1'b1, 32'd4000, 32'd13);
        target = rsp_count + 5;
        for (int i = 0; i < 400 && rsp_count < target; i++) begin
            tick();
            if (acc_seen && acc_idx == 0 && !rereq) begin
                set_req(0, 1'b1, 32'd555, 32'd5);
                rereq = 1'b1;
            end
        end
        tests_run++;
        if (grant_log.size() != 5 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 2 || grant_log[3] != 3 || grant_log[4] != 0) begin
            tests_failed++;
            $display("FAIL rr_order: got %p, required '{0,1,2,3,0}", grant_log);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] q0, r0;
        rsp_ready = 4'b0111;
        set_req(3, 1'b1, 32'd77, 32'd5);
        tick();
        set_req(1, 1'b1, 32'd9, 32'd2);
        for (int i = 0; i < 50 && cur_rsp_valid == '0; i++) tick();
        q0 = cur_q;
        r0 = cur_r;
        tests_run++;
        if (cur_rsp_valid !== 4'b1000 || q0 !== 32'd15 || r0 !== 32'd2) begin
            tests_failed++;
            $display("FAIL bp_first: got valid=%b q=%0d r=%0d, required 1000 15 2", cur_rsp_valid, q0, r0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (cur_rsp_valid !== 4'b1000 || cur_q !== q0 || cur_r !== r0 ||
                cur_start !== 1'b0 || cur_req_ready !== '0) begin
                tests_failed++;
                $display("FAIL bp_hold: got valid=%b q=%h r=%h start=%b ready=%b, required 1000 %h %h 0 0000",
                         cur_rsp_valid, cur_q, cur_r, cur_start, cur_req_ready, q0, r0);
            end
        end
        rsp_ready = '1;
        wait_rsp("bp3");
        wait_rsp("bp1");
        tests_run++;
        if (hs_valid !== 4'b0010 || hs_q !== 32'd4 || hs_r !== 32'd1) begin
            tests_failed++;
            $display("FAIL bp_second: got valid=%b q=%0d r=%0d, required 0010 4 1", hs_valid, hs_q, hs_r);
        end
    endtask

    task automatic test_reset_mid();
        int cnt0;
        set_req(2, 1'b1, 32'd200, 32'd9);
        for (int i = 0; i < 20 && !cur_busy; i++) tick();
        tick();
        rstnn = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== '0 || req_ready !== '0 || div_start !== 1'b0 ||
            rsp_quotient !== '0 || rsp_remainder !== '0) begin
            tests_failed++;
            $display("FAIL mid_rst_outputs: got valid=%b ready=%b start=%b q=%h r=%h, required all 0",
                     rsp_valid, req_ready, div_start, rsp_quotient, rsp_remainder);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        cnt0 = rsp_count;
        first_rsp_cycle = -1;
        repeat (10) tick();
        tests_run++;
        if (rsp_count != cnt0 || first_rsp_cycle >= 0) begin
            tests_failed++;
            $display("FAIL mid_rst_no_rsp: got %0d responses, required 0", rsp_count - cnt0);
        end
        set_req(1, 1'b1, 32'd45, 32'd6);
        tick();
        wait_rsp("after_rst");
        tests_run++;
        if (hs_valid !== 4'b0010 || hs_q !== 32'd7 || hs_r !== 32'd3) begin
            tests_failed++;
            $display("FAIL after_rst: got valid=%b q=%0d r=%0d, required 0010 7 3", hs_valid, hs_q, hs_r);
        end
    endtask

    task automatic test_cache();
        set_req(1, 1'b1, 32'd100, 32'd7);
        tick();
        wait_rsp("c_fill");
        set_req(1, 1'b1, 32'd100, 32'd7);
        first_rsp_cycle = -1;
        tick();
        wait_rsp("c_hit");
        tests_run += 2;
        if (hs_q !== 32'd14 || hs_r !== 32'd2) begin
            tests_failed++;
            $display("FAIL c_result: got q=%0d r=%0d, required 14 2", hs_q, hs_r);
        end
`ifdef DIVIDER_SHARE_CTRL_CACHE_EN
        if (acc_start !== 1'b0 || first_rsp_cycle - acc_cycle != 1) begin
            tests_failed++;
            $display("FAIL c_hit_path: got start=%b latency=%0d, required 0 1",
                     acc_start, first_rsp_cycle - acc_cycle);
        end
`else
        if (acc_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL c_nocache_start: got start=%b, required 1", acc_start);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstnn           = 1'b0;
        req_valid       = '0;
        rsp_ready       = '1;
        req_is_unsigned = '0;
        req_numerator   = '0;
        req_denominator = '0;
        test_reset();
        test_unsigned_basic();
        test_signed_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_cache();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
